pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_slot.sv | 34 +++
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and default widths.
package pipe_pkg;

   localparam int unsigned CTRL_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned LANES_DEF  = 5;
   localparam int unsigned DST_W_DEF  = 4;

   // Encoding equals the number of held beats.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   function automatic logic [1:0] occ_of(input state_t s);
      return 2'(s);
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload entry: load-enabled register with async clear and a synchronous ctrl kill.
module pipe_slot #(
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned PAY_W  = 160,
   parameter int unsigned DST_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              kill,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [PAY_W-1:0]  d_data,
   input  logic [DST_W-1:0]  d_dst,
   output logic [CTRL_W-1:0] q_ctrl,
   output logic [PAY_W-1:0]  q_data,
   output logic [DST_W-1:0]  q_dst
);

   // Kill only zeroes ctrl so a dead entry can never carry an enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_ctrl <= '0;
         q_data <= '0;
         q_dst  <= '0;
      end else if (kill) begin
         q_ctrl <= '0;
      end else if (load) begin
         q_ctrl <= d_ctrl;
         q_data <= d_data;
         q_dst  <= d_dst;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register built as a 2-entry skid buffer with flush and registered ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = CTRL_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned LANES  = LANES_DEF,
   parameter int unsigned DST_W  = DST_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CTRL_W-1:0]       in_ctrl,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic [DST_W-1:0]        in_dst,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CTRL_W-1:0]       out_ctrl,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [DST_W-1:0]        out_dst,
   output logic [1:0]              occupancy
);

   localparam int unsigned PAY_W = LANES * DATA_W;

   state_t state, state_nxt;

   logic in_fire_c, out_fire_c;
   logic main_load_c, main_kill_c, main_from_skid_c;
   logic skid_load_c, skid_kill_c;

   logic [CTRL_W-1:0] skid_ctrl;
   logic [PAY_W-1:0]  skid_data;
   logic [DST_W-1:0]  skid_dst;

   logic [CTRL_W-1:0] main_d_ctrl;
   logic [PAY_W-1:0]  main_d_data;
   logic [DST_W-1:0]  main_d_dst;

   // Next state and entry controls; flush overrides every transfer.
   always_comb begin
      state_nxt        = state;
      main_load_c      = 1'b0;
      main_kill_c      = 1'b0;
      main_from_skid_c = 1'b0;
      skid_load_c      = 1'b0;
      skid_kill_c      = 1'b0;
      in_fire_c        = in_valid & in_ready;
      out_fire_c       = out_valid & out_ready;

      if (flush) begin
         state_nxt   = EMPTY;
         main_kill_c = 1'b1;
         skid_kill_c = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire_c) begin
                  state_nxt   = ONE;
                  main_load_c = 1'b1;
               end
            end
            ONE: begin
               case ({in_fire_c, out_fire_c})
                  2'b11: main_load_c = 1'b1;
                  2'b01: begin
                     state_nxt   = EMPTY;
                     main_kill_c = 1'b1;
                  end
                  2'b10: begin
                     state_nxt   = FULL;
                     skid_load_c = 1'b1;
                  end
                  default: ;
               endcase
            end
            FULL: begin
               if (out_fire_c) begin
                  state_nxt        = ONE;
                  main_load_c      = 1'b1;
                  main_from_skid_c = 1'b1;
                  skid_kill_c      = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end

      main_d_ctrl = main_from_skid_c ? skid_ctrl : in_ctrl;
      main_d_data = main_from_skid_c ? skid_data : in_data;
      main_d_dst  = main_from_skid_c ? skid_dst  : in_dst;
   end

   // State plus its registered decodes, so no output depends on out_ready combinationally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt != FULL);
         out_valid <= (state_nxt != EMPTY);
         occupancy <= occ_of(state_nxt);
      end
   end

   pipe_slot #(
      .CTRL_W (CTRL_W),
      .PAY_W  (PAY_W),
      .DST_W  (DST_W)
   ) u_main (
      .clk    (clk),
      .reset  (reset),
      .load   (main_load_c),
      .kill   (main_kill_c),
      .d_ctrl (main_d_ctrl),
      .d_data (main_d_data),
      .d_dst  (main_d_dst),
      .q_ctrl (out_ctrl),
      .q_data (out_data),
      .q_dst  (out_dst)
   );

   pipe_slot #(
      .CTRL_W (CTRL_W),
      .PAY_W  (PAY_W),
      .DST_W  (DST_W)
   ) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load_c),
      .kill   (skid_kill_c),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .d_dst  (in_dst),
      .q_ctrl (skid_ctrl),
      .q_data (skid_data),
      .q_dst  (skid_dst)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard checks for pipe_stage_reg at default and two swept configurations.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Default configuration
   logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [15:0]  in_ctrl = '0, out_ctrl;
   logic [159:0] in_data = '0, out_data;
   logic [3:0]   in_dst = '0, out_dst;
   logic [1:0]   occupancy;

   pipe_stage_reg dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .in_dst(in_dst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data), .out_dst(out_dst),
      .occupancy(occupancy)
   );

   // Narrow configuration: LANES=1, DATA_W=8
   logic        a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0;
   logic [3:0]  a_ictrl = '0, a_octrl;
   logic [7:0]  a_idata = '0, a_odata;
   logic [1:0]  a_idst = '0, a_odst, a_occ;

   pipe_stage_reg #(.CTRL_W(4), .DATA_W(8), .LANES(1), .DST_W(2)) dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(a_iv), .in_ready(a_ir),
      .in_ctrl(a_ictrl), .in_data(a_idata), .in_dst(a_idst),
      .out_valid(a_ov), .out_ready(a_or),
      .out_ctrl(a_octrl), .out_data(a_odata), .out_dst(a_odst),
      .occupancy(a_occ)
   );

   // Wide configuration: LANES=6, DATA_W=64
   logic         b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0;
   logic [15:0]  b_ictrl = '0, b_octrl;
   logic [383:0] b_idata = '0, b_odata;
   logic [3:0]   b_idst = '0, b_odst;
   logic [1:0]   b_occ;

   pipe_stage_reg #(.CTRL_W(16), .DATA_W(64), .LANES(6), .DST_W(4)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(b_iv), .in_ready(b_ir),
      .in_ctrl(b_ictrl), .in_data(b_idata), .in_dst(b_idst),
      .out_valid(b_ov), .out_ready(b_or),
      .out_ctrl(b_octrl), .out_data(b_odata), .out_dst(b_odst),
      .occupancy(b_occ)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [159:0] lanes_of(input logic [31:0] lane0);
      return {32'hD4D4_0004, 32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, lane0};
   endfunction

   task automatic test_reset();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || occupancy !== 2'd0) begin
         bad++;
         $display("FAIL reset_flags: out_valid=%b in_ready=%b occ=%0d want 0/0/0", out_valid, in_ready, occupancy);
      end
      total++;
      if (out_ctrl !== 16'h0 || out_data !== 160'h0 || out_dst !== 4'h0) begin
         bad++;
         $display("FAIL reset_payload: ctrl=%h data=%h dst=%h want zero", out_ctrl, out_data, out_dst);
      end
      step();
      reset = 1'b1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_early: in_ready=%b want 0", in_ready);
      end
      step();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 16'h00C3;
      for (int i = 1; i <= 8; i++) begin
         in_data = lanes_of(32'(i));
         in_dst  = 4'(i);
         step();
         total++;
         if (out_valid !== 1'b1 || out_data !== lanes_of(32'(i)) || out_dst !== 4'(i) ||
             out_ctrl !== 16'h00C3 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stream_beat%0d: valid=%b lane0=%h dst=%h ctrl=%h occ=%0d rdy=%b want 1/%0h/%0h/00c3/1/1",
                     i, out_valid, out_data[31:0], out_dst, out_ctrl, occupancy, in_ready, i, i);
         end
      end
      in_valid = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 16'h0) begin
         bad++;
         $display("FAIL stream_drain: valid=%b occ=%0d ctrl=%h want 0/0/0", out_valid, occupancy, out_ctrl);
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 16'h0011;
      in_data   = lanes_of(32'h10);
      step();
      in_data = lanes_of(32'h11);
      step();
      in_data = lanes_of(32'h12);
      step();
      total++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data[31:0] !== 32'h10) begin
         bad++;
         $display("FAIL stall_full: occ=%0d in_ready=%b lane0=%h want 2/0/10", occupancy, in_ready, out_data[31:0]);
      end
      out_ready = 1'b1;
      step();
      total++;
      if (out_valid !== 1'b1 || out_data[31:0] !== 32'h11 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL stall_drain1: valid=%b lane0=%h occ=%0d rdy=%b want 1/11/1/1", out_valid, out_data[31:0], occupancy, in_ready);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || out_data[31:0] !== 32'h12 || occupancy !== 2'd1) begin
         bad++;
         $display("FAIL stall_drain2: valid=%b lane0=%h occ=%0d want 1/12/1", out_valid, out_data[31:0], occupancy);
      end
      in_valid = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         bad++;
         $display("FAIL stall_empty: valid=%b occ=%0d want 0/0", out_valid, occupancy);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 16'h0F0F;
      in_data   = lanes_of(32'h20);
      step();
      in_data = lanes_of(32'h21);
      step();
      total++;
      if (occupancy !== 2'd2) begin
         bad++;
         $display("FAIL flush_fill: occ=%0d want 2", occupancy);
      end
      flush   = 1'b1;
      in_data = lanes_of(32'h55);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_kill: valid=%b ctrl=%h occ=%0d rdy=%b want 0/0/0/1", out_valid, out_ctrl, occupancy, in_ready);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin
            bad++;
            $display("FAIL flush_ghost%0d: valid=%b lane0=%h want no beat", i, out_valid, out_data[31:0]);
         end
      end
   endtask

   task automatic test_bubble();
      in_valid = 1'b0;
      in_ctrl  = 16'hFFFF;
      in_data  = lanes_of(32'hBB);
      for (int i = 0; i < 4; i++) begin
         out_ready = i[0];
         step();
         total++;
         if (out_ctrl !== 16'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bubble%0d: ctrl=%h valid=%b want 0/0", i, out_ctrl, out_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 16'h0A0A;
      in_data   = lanes_of(32'hA1);
      step();
      in_data = lanes_of(32'hA2);
      step();
      in_valid = 1'b0;
      total++;
      if (occupancy !== 2'd2 || out_data[31:0] !== 32'hA1) begin
         bad++;
         $display("FAIL midrst_fill: occ=%0d lane0=%h want 2/a1", occupancy, out_data[31:0]);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0 || out_ctrl !== 16'h0 || out_data !== 160'h0) begin
         bad++;
         $display("FAIL midrst_async: valid=%b occ=%0d rdy=%b ctrl=%h want 0/0/0/0", out_valid, occupancy, in_ready, out_ctrl);
      end
      step();
      reset = 1'b1;
      step();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0) begin
         bad++;
         $display("FAIL midrst_release: rdy=%b valid=%b occ=%0d want 1/0/0", in_ready, out_valid, occupancy);
      end
   endtask

   task automatic test_sweep();
      logic [13:0]  qa[$];
      logic [403:0] qb[$];
      logic [13:0]  ea;
      logic [403:0] eb;
      int a_sent = 0, a_rcv = 0, b_sent = 0, b_rcv = 0, cyc = 0;
      logic a_pend = 1'b0, b_pend = 1'b0;
      while ((a_rcv < 1000 || b_rcv < 1000) && cyc < 20000) begin
         if (!a_pend) begin
            a_iv = (a_sent < 1000) && ($urandom_range(3) != 0);
            a_ictrl = 4'($urandom);
            a_idata = 8'($urandom);
            a_idst = 2'($urandom);
         end
         if (!b_pend) begin
            b_iv = (b_sent < 1000) && ($urandom_range(3) != 0);
            b_ictrl = 16'($urandom);
            for (int k = 0; k < 12; k++) b_idata[k*32 +: 32] = $urandom;
            b_idst = 4'($urandom);
         end
         a_or = ($urandom_range(2) != 0);
         b_or = ($urandom_range(2) != 0);
         #7;
         if (a_ov && a_or) begin
            total++;
            ea = (qa.size() > 0) ? qa.pop_front() : 14'h3FFF;
            if ({a_octrl, a_odst, a_odata} !== ea || a_occ === 2'd3) begin
               bad++;
               $display("FAIL sweep_a_beat%0d: got %h want %h", a_rcv, {a_octrl, a_odst, a_odata}, ea);
            end
            a_rcv++;
         end
         if (a_iv && a_ir) begin
            qa.push_back({a_ictrl, a_idst, a_idata});
            a_sent++;
         end
         a_pend = a_iv && !a_ir;
         if (b_ov && b_or) begin
            total++;
            eb = (qb.size() > 0) ? qb.pop_front() : '1;
            if ({b_octrl, b_odst, b_odata} !== eb || b_occ === 2'd3) begin
               bad++;
               $display("FAIL sweep_b_beat%0d: got lane0=%h want lane0=%h", b_rcv, b_odata[63:0], eb[63:0]);
            end
            b_rcv++;
         end
         if (b_iv && b_ir) begin
            qb.push_back({b_ictrl, b_idst, b_idata});
            b_sent++;
         end
         b_pend = b_iv && !b_ir;
         cyc++;
         step();
      end
      a_iv = 1'b0;
      b_iv = 1'b0;
      total++;
      if (a_rcv != 1000 || b_rcv != 1000 || qa.size() != 0 || qb.size() != 0) begin
         bad++;
         $display("FAIL sweep_count: a_rcv=%0d b_rcv=%0d left=%0d/%0d want 1000/1000/0/0",
                  a_rcv, b_rcv, qa.size(), qb.size());
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_bubble();
      test_reset_mid();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
